// File: rtl/debounce_edge.sv
// Debouncer for a raw asynchronous level: 2-flop synchroniser, then a 4-state qualification FSM.
// A new level is accepted after N consecutive matching samples, with one-cycle rise/fall pulses.
module debounce_edge #(
   parameter int isposedge = 1,
   parameter int ini       = 0,
   parameter int N         = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   input  logic en,
   output logic q,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int              CW       = $clog2(N + 1);
   localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
   localparam logic            INI_LVL  = (ini != 0);

   typedef enum logic [1:0] {
      STABLE_0 = 2'd0,
      CHECK_1  = 2'd1,
      STABLE_1 = 2'd2,
      CHECK_0  = 2'd3
   } state_t;

   localparam state_t ST_INI = INI_LVL ? STABLE_1 : STABLE_0;

   logic          act_clk;
   logic          s1_q, s1_d;
   logic          s_q, s_d;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          q_q, q_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic          busy_q, busy_d;

   // Falling-edge variant simply runs every register off the inverted clock.
   assign act_clk = (isposedge != 0) ? clk : ~clk;

   // Next-state, counter and pulse logic; nothing but the synchroniser moves while en is low.
   always_comb begin
      s1_d    = din;
      s_d     = s1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (en) begin
         case (state_q)
            STABLE_0: begin
               if (s_q) begin
                  if (N == 1) begin
                     state_d = STABLE_1;
                     rise_d  = 1'b1;
                  end else begin
                     state_d = CHECK_1;
                     cnt_d   = CNT_ONE;
                  end
               end else begin
                  state_d = STABLE_0;
               end
            end
            CHECK_1: begin
               if (!s_q) begin
                  state_d = STABLE_0;
                  cnt_d   = CNT_ZERO;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = STABLE_1;
                  cnt_d   = CNT_ZERO;
                  rise_d  = 1'b1;
               end else begin
                  cnt_d   = cnt_q + CNT_ONE;
               end
            end
            STABLE_1: begin
               if (!s_q) begin
                  if (N == 1) begin
                     state_d = STABLE_0;
                     fall_d  = 1'b1;
                  end else begin
                     state_d = CHECK_0;
                     cnt_d   = CNT_ONE;
                  end
               end else begin
                  state_d = STABLE_1;
               end
            end
            CHECK_0: begin
               if (s_q) begin
                  state_d = STABLE_1;
                  cnt_d   = CNT_ZERO;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = STABLE_0;
                  cnt_d   = CNT_ZERO;
                  fall_d  = 1'b1;
               end else begin
                  cnt_d   = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ST_INI;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end else begin
         state_d = state_q;
      end
      q_d    = (state_d == STABLE_1) || (state_d == CHECK_0);
      busy_d = (state_d == CHECK_1)  || (state_d == CHECK_0);
   end

   // All state, including the synchroniser, shares one asynchronous reset.
   always_ff @(posedge act_clk or negedge rst) begin
      if (!rst) begin
         s1_q    <= INI_LVL;
         s_q     <= INI_LVL;
         state_q <= ST_INI;
         cnt_q   <= CNT_ZERO;
         q_q     <= INI_LVL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s_q     <= s_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   assign q    = q_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = busy_q;

endmodule

// File: doc/debounce_edge.md
DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 The block SHALL have parameter isposedge, default 1: 1 = registers update on rising clk, 0 = on falling clk.
REQ-002 The block SHALL have parameter ini, default 0: reset level of synchroniser stages, q and FSM stable state.
REQ-003 The block SHALL have parameter N, default 4: consecutive synchronised samples required to accept a level change, legal range 1..65535.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port din, input, 1 bit: raw asynchronous level, e.g. a pin or switch.
REQ-007 The block SHALL have port en, input, 1 bit: FSM/counter advance enable.
REQ-008 The block SHALL have port q, output, 1 bit: debounced level, registered.
REQ-009 The block SHALL have port rise, output, 1 bit: one-cycle pulse when q goes 0->1, registered.
REQ-010 The block SHALL have port fall, output, 1 bit: one-cycle pulse when q goes 1->0, registered.
REQ-011 The block SHALL have port busy, output, 1 bit: high while the FSM is in CHECK_0 or CHECK_1, registered.
REQ-012 The block SHALL use one clock and an asynchronous active-low reset named rst, with clk as the clock port name.

Function
REQ-013 din SHALL pass through a 2-flop synchroniser (s1 -> s); s1 and s SHALL update every active edge, independent of en.
REQ-014 The FSM SHALL have exactly four states: STABLE_0, CHECK_1, STABLE_1, CHECK_0; q = 1 in STABLE_1 and CHECK_0, q = 0 otherwise.
REQ-015 The counter cnt SHALL be clog2(N+1) bits wide, unsigned, and SHALL never exceed N-1.
REQ-016 In STABLE_0 with s=1, the next state SHALL be CHECK_1 with cnt<=1; for N=1 the next state SHALL be STABLE_1 directly; with s=0 the FSM SHALL hold.
REQ-017 In CHECK_1 with s=0, the next state SHALL be STABLE_0 with cnt<=0 (glitch rejected, no pulse).
REQ-018 In CHECK_1 with s=1 and cnt==N-1, the next state SHALL be STABLE_1 with cnt<=0 and rise<=1.
REQ-019 In CHECK_1 with s=1 and cnt<N-1, cnt SHALL increment.
REQ-020 STABLE_1 and CHECK_0 SHALL mirror REQ-016 to REQ-019 with s inverted and fall in place of rise.
REQ-021 Acceptance latency SHALL be exactly N+2 active edges from the first edge sampling a new stable din level to q changing; rise/fall SHALL assert on the same edge as q.
REQ-022 rise and fall SHALL each be high for exactly one cycle, SHALL never both be high, and SHALL be 0 whenever en=0.
REQ-023 When en=0, state, cnt and q SHALL hold; the synchroniser continues; on en returning to 1, evaluation SHALL resume from the held cnt.
REQ-024 Any s mismatch during CHECK SHALL restart the qualification from zero; partial counts SHALL NOT accumulate across glitches.
REQ-025 busy SHALL equal (state is CHECK_0 or CHECK_1), registered with the state.

Reset
REQ-026 On rst=0, asynchronously: s1=s=ini, state=STABLE_ini, q=ini, cnt=0, rise=fall=0, busy=0.
REQ-027 Reset asserted mid-CHECK SHALL abort qualification with no pulse; after release the FSM SHALL restart from STABLE_ini.
REQ-028 After rst release, the first FSM evaluation SHALL occur on the first active edge.

Verification
REQ-029 The bench SHALL cover: N=4, ini=0, en=1; din 0->1 held -> q=1 and rise=1 for one cycle exactly 6 edges later; busy high for the preceding 3 cycles.
REQ-030 The bench SHALL cover: N=4; din high for 3 cycles then low -> q stays 0, rise never asserts, busy returns to 0.
REQ-031 The bench SHALL cover: N=4, q=1; din 1->0 held, en=0 for 2 cycles mid-CHECK_0 -> fall asserts 8 edges after the change, single cycle.
REQ-032 The bench SHALL cover: N=1; din toggles every 5 cycles -> q follows with a 3-edge lag and alternating rise/fall pulses.
REQ-033 The bench SHALL cover: N=4, ini=1; rst asserted during CHECK_0 -> q=1 immediately, no fall pulse, busy=0.
REQ-034 The bench SHALL cover: isposedge=0, with the REQ-029 stimulus -> identical results counted on falling edges.
